// File: rtl/fifo_vec.sv
// Single-clock multi-lane FIFO with occupancy count, almost-full, sticky error flags.
// Define FIFO_VEC_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_vec #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int LANES        = 3,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] din [LANES-1:0],
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic signed [DATA_WIDTH-1:0] dout [LANES-1:0],
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = LANES * DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [EW-1:0] wr_word;
  logic [EW-1:0] rd_word;
  logic          wr_acc, rd_acc;

  // Flags come from the registered count only, so accept terms see start-of-cycle state.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_word = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_word[l*DATA_WIDTH +: DATA_WIDTH] = din[l];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately not reset; only the pointers define valid contents.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_VEC_FWFT_EN
  // Head entry is presented directly; undefined contents while empty.
  assign rd_word = mem_q[rd_ptr_q];
`else
  logic [EW-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign rd_word = dout_q;
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      dout[l] = rd_word[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_vec.sv
// Directed bench for fifo_vec (DEPTH=16, LANES=3, DATA_WIDTH=32).
// Expectations are written for the default registered-read build.
module tb_fifo_vec;

  logic               clock = 1'b0;
  logic               reset;
  logic               wr_en;
  logic               rd_en;
  logic signed [31:0] din  [2:0];
  logic signed [31:0] dout [2:0];
  logic               full, almost_full, empty, overflow, underflow;
  logic [4:0]         count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [95:0] exp_q[$];

  fifo_vec #(.DATA_WIDTH(32), .DEPTH(16), .LANES(3)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it, away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_din(input int a, input int b, input int c);
    din[0] = a;
    din[1] = b;
    din[2] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_flags: empty=%b full=%b afull=%b count=%0d, want 1 0 0 0", empty, full, almost_full, count);
    end
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: ovf=%b unf=%b, want 0 0", overflow, underflow);
    end
    n_cmp++;
    if (dout[0] !== 32'sd0 || dout[1] !== 32'sd0 || dout[2] !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_dout: {%0d,%0d,%0d}, want {0,0,0}", dout[0], dout[1], dout[2]);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      set_din(i, -i, 1000 + i);
      wr_en = 1'b1;
      step();
      n_cmp++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)
          || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d afull=%b full=%b empty=%b, want %0d %b %b 0",
                 i, count, almost_full, full, empty, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_no_ovf: ovf=%b, want 0", overflow);
    end
    set_din(99, -99, 1099);
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_write: ovf=%b count=%0d full=%b, want 1 16 1", overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      n_cmp++;
      if (dout[0] !== 32'(i) || dout[1] !== 32'(-i) || dout[2] !== 32'(1000 + i)
          || count !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain_%0d: dout={%0d,%0d,%0d} count=%0d, want {%0d,%0d,%0d} %0d",
                 i, dout[0], dout[1], dout[2], count, i, -i, 1000 + i, 15 - i);
      end
    end
    n_cmp++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: unf=%b empty=%b, want 0 1", underflow, empty);
    end
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1 || count !== 5'd0 ||
        dout[0] !== 32'sd15 || dout[1] !== -32'sd15 || dout[2] !== 32'sd1015) begin
      n_fail++;
      $display("FAIL underflow_read: unf=%b count=%0d dout={%0d,%0d,%0d}, want 1 0 {15,-15,1015}",
               underflow, count, dout[0], dout[1], dout[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    logic [95:0] got;
    int v = 100;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      set_din(v, -v, 2 * v);
      exp_q.push_back({32'(2 * v), 32'(-v), 32'(v)});
      v++;
      wr_en = 1'b1;
      step();
    end
    rd_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      set_din(v, -v, 2 * v);
      exp_q.push_back({32'(2 * v), 32'(-v), 32'(v)});
      v++;
      step();
      exp = exp_q.pop_front();
      got = {dout[2], dout[1], dout[0]};
      n_cmp++;
      if (got !== exp || count !== 5'd8) begin
        n_fail++;
        $display("FAIL b2b_%0d: dout=%h count=%0d, want %h 8", c, got, count, exp);
      end
    end
    rd_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_err: ovf=%b unf=%b, want 0 0", overflow, underflow);
    end
    // Top up to full, then request both: read must win, write must be dropped.
    for (int k = 0; k < 8; k++) begin
      set_din(v, -v, 2 * v);
      exp_q.push_back({32'(2 * v), 32'(-v), 32'(v)});
      v++;
      step();
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL topup_full: full=%b count=%0d, want 1 16", full, count);
    end
    set_din(-1, -1, -1);
    rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    exp = exp_q.pop_front();
    got = {dout[2], dout[1], dout[0]};
    n_cmp++;
    if (count !== 5'd15 || overflow !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL full_wr_rd: count=%0d ovf=%b dout=%h, want 15 1 %h", count, overflow, got, exp);
    end
  endtask

  task automatic test_empty_wr_rd();
    do_reset();
    set_din(5, 6, 7);
    wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if (count !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0 ||
        dout[0] !== 32'sd0 || dout[1] !== 32'sd0 || dout[2] !== 32'sd0) begin
      n_fail++;
      $display("FAIL empty_wr_rd: count=%0d unf=%b ovf=%b dout={%0d,%0d,%0d}, want 1 1 0 {0,0,0}",
               count, underflow, overflow, dout[0], dout[1], dout[2]);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (dout[0] !== 32'sd5 || dout[1] !== 32'sd6 || dout[2] !== 32'sd7 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_wr_rd_data: dout={%0d,%0d,%0d} empty=%b, want {5,6,7} 1",
               dout[0], dout[1], dout[2], empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 9; k++) begin
      set_din(k, k, k);
      wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd9 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: count=%0d unf=%b, want 9 1", count, underflow);
    end
    do_reset();
    #1;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d empty=%b ovf=%b unf=%b, want 0 1 0 0",
               count, empty, overflow, underflow);
    end
    set_din(7, 8, 9);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
`ifdef FIFO_VEC_FWFT_EN
    n_cmp++;
    if (dout[0] !== 32'sd7 || dout[1] !== 32'sd8 || dout[2] !== 32'sd9) begin
      n_fail++;
      $display("FAIL fwft_head: dout={%0d,%0d,%0d}, want {7,8,9}", dout[0], dout[1], dout[2]);
    end
`endif
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
`ifndef FIFO_VEC_FWFT_EN
    n_cmp++;
    if (dout[0] !== 32'sd7 || dout[1] !== 32'sd8 || dout[2] !== 32'sd9) begin
      n_fail++;
      $display("FAIL mid_readback: dout={%0d,%0d,%0d}, want {7,8,9}", dout[0], dout[1], dout[2]);
    end
`endif
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_read: count=%0d empty=%b, want 0 1", count, empty);
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    set_din(0, 0, 0);
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_wr_rd();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
